// File: rtl/trace_capture_ctrl.sv
// Sequences one trace capture: arm, wait for sync, wait for trigger, then gate I_capture_len words into the FIFO.
// The FIFO write strobe is combinational from registered state; the write is held off while the FIFO is full.
module trace_capture_ctrl #(
    parameter int pMATCH_RULES   = 8,
    parameter int pCOUNT_WIDTH   = 16,
    parameter int pTIMEOUT_WIDTH = 24
) (
    input  logic                      usb_clk,
    input  logic                      reset_i,
    input  logic                      I_arm,
    input  logic                      I_abort,
    input  logic                      I_synchronized,
    input  logic                      I_match_valid,
    input  logic [pMATCH_RULES-1:0]   I_match_rules,
    input  logic [pMATCH_RULES-1:0]   I_pattern_trig_enable,
    input  logic                      I_soft_trig,
    input  logic                      I_soft_trig_enable,
    input  logic [pCOUNT_WIDTH-1:0]   I_capture_len,
    input  logic [pTIMEOUT_WIDTH-1:0] I_timeout_cycles,
    input  logic                      I_data_valid,
    input  logic                      I_fifo_full,
    output logic                      O_fifo_wr,
    output logic [2:0]                O_state,
    output logic                      O_busy,
    output logic                      O_done,
    output logic                      O_trig_out,
    output logic [pMATCH_RULES-1:0]   O_trig_rule,
    output logic [pCOUNT_WIDTH-1:0]   O_samples,
    output logic                      O_timeout,
    output logic                      O_overflow,
    output logic                      O_sync_lost
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_SYNC = 3'd1;
    localparam logic [2:0] ARMED     = 3'd2;
    localparam logic [2:0] CAPTURE   = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam logic [pTIMEOUT_WIDTH-1:0] TMO_ONE = {{(pTIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [pCOUNT_WIDTH-1:0]   CNT_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]                state;
    logic [pTIMEOUT_WIDTH-1:0] tmo_cnt;
    logic [pMATCH_RULES-1:0]   masked_rules;
    logic                      trig;
    logic                      tmo_hit;
    logic                      last_word;

    // Soft-only triggers latch a zero rule vector because masking includes I_match_valid.
    assign masked_rules = I_match_rules & I_pattern_trig_enable & {pMATCH_RULES{I_match_valid}};
    assign trig         = (|masked_rules) | (I_soft_trig & I_soft_trig_enable);
    assign tmo_hit      = (I_timeout_cycles != '0) && (tmo_cnt == I_timeout_cycles - TMO_ONE);
    assign last_word    = (O_samples + CNT_ONE) == I_capture_len;

    assign O_fifo_wr = (state == CAPTURE) & I_data_valid & ~I_fifo_full & ~reset_i;
    assign O_state   = state;
    assign O_busy    = (state == WAIT_SYNC) | (state == ARMED) | (state == CAPTURE);
    assign O_done    = (state == DONE);

    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            O_trig_out  <= 1'b0;
            O_trig_rule <= '0;
            O_samples   <= '0;
            O_timeout   <= 1'b0;
            O_overflow  <= 1'b0;
            O_sync_lost <= 1'b0;
        end else begin
            O_trig_out <= 1'b0;
            if (I_abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (I_arm) begin
                            state       <= WAIT_SYNC;
                            tmo_cnt     <= '0;
                            O_trig_rule <= '0;
                            O_samples   <= '0;
                            O_timeout   <= 1'b0;
                            O_overflow  <= 1'b0;
                            O_sync_lost <= 1'b0;
                        end
                    end
                    WAIT_SYNC: begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                        if (tmo_hit) begin
                            state     <= DONE;
                            O_timeout <= 1'b1;
                        end else if (I_synchronized) begin
                            state <= ARMED;
                        end
                    end
                    ARMED: begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                        if (trig) begin
                            O_trig_rule <= masked_rules;
                            O_trig_out  <= 1'b1;
                            state       <= (I_capture_len == '0) ? DONE : CAPTURE;
                        end else if (tmo_hit) begin
                            state     <= DONE;
                            O_timeout <= 1'b1;
                        end else if (!I_synchronized) begin
                            state <= WAIT_SYNC;
                        end
                    end
                    CAPTURE: begin
                        if (O_fifo_wr) begin
                            O_samples <= O_samples + CNT_ONE;
                            if (last_word) state <= DONE;
                        end
                        if (I_data_valid && I_fifo_full) O_overflow <= 1'b1;
                        // A write on the sync-loss cycle still lands and is counted above.
                        if (!I_synchronized) begin
                            O_sync_lost <= 1'b1;
                            state       <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl: trigger, timeout, overflow, soft trigger, sync loss, abort and reset.
module tb_trace_capture_ctrl;

    logic        usb_clk = 1'b0;
    logic        reset_i;
    logic        I_arm, I_abort, I_synchronized, I_match_valid;
    logic [7:0]  I_match_rules, I_pattern_trig_enable;
    logic        I_soft_trig, I_soft_trig_enable;
    logic [15:0] I_capture_len;
    logic [23:0] I_timeout_cycles;
    logic        I_data_valid, I_fifo_full;
    logic        O_fifo_wr;
    logic [2:0]  O_state;
    logic        O_busy, O_done, O_trig_out;
    logic [7:0]  O_trig_rule;
    logic [15:0] O_samples;
    logic        O_timeout, O_overflow, O_sync_lost;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int bad_wr = 0;

    trace_capture_ctrl dut (
        .usb_clk(usb_clk), .reset_i(reset_i), .I_arm(I_arm), .I_abort(I_abort),
        .I_synchronized(I_synchronized), .I_match_valid(I_match_valid),
        .I_match_rules(I_match_rules), .I_pattern_trig_enable(I_pattern_trig_enable),
        .I_soft_trig(I_soft_trig), .I_soft_trig_enable(I_soft_trig_enable),
        .I_capture_len(I_capture_len), .I_timeout_cycles(I_timeout_cycles),
        .I_data_valid(I_data_valid), .I_fifo_full(I_fifo_full), .O_fifo_wr(O_fifo_wr),
        .O_state(O_state), .O_busy(O_busy), .O_done(O_done), .O_trig_out(O_trig_out),
        .O_trig_rule(O_trig_rule), .O_samples(O_samples), .O_timeout(O_timeout),
        .O_overflow(O_overflow), .O_sync_lost(O_sync_lost)
    );

    always #5 usb_clk = ~usb_clk;

    always @(posedge usb_clk) begin
        if (O_fifo_wr) wr_cnt++;
        if (O_fifo_wr && I_fifo_full) bad_wr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge usb_clk);
            #1;
        end
    endtask

    task automatic pulse_arm();
        I_arm = 1'b1;
        tick(1);
        I_arm = 1'b0;
    endtask

    task automatic match_trig();
        I_match_valid = 1'b1;
        I_match_rules = 8'h04;
        tick(1);
        I_match_valid = 1'b0;
        I_match_rules = 8'h00;
    endtask

    initial begin
        reset_i = 1'b1; I_arm = 0; I_abort = 0; I_synchronized = 0; I_match_valid = 0;
        I_match_rules = 0; I_pattern_trig_enable = 0; I_soft_trig = 0; I_soft_trig_enable = 0;
        I_capture_len = 0; I_timeout_cycles = 0; I_data_valid = 0; I_fifo_full = 0;
        tick(2);
        reset_i = 1'b0;
        tick(1);
        chk("rst_state", O_state, 0);
        chk("rst_busy", O_busy, 0);
        chk("rst_done", O_done, 0);
        chk("rst_samples", O_samples, 0);
        chk("rst_flags", {O_timeout, O_overflow, O_sync_lost, O_trig_out}, 0);
        chk("rst_rule", O_trig_rule, 0);

        // Pattern trigger on rule 2, capture 4 words
        I_synchronized = 1; I_capture_len = 4; I_pattern_trig_enable = 8'h04;
        pulse_arm();
        chk("t1_wait_sync", O_state, 1);
        chk("t1_busy", O_busy, 1);
        tick(1);
        chk("t1_armed", O_state, 2);
        I_match_valid = 1; I_match_rules = 8'h05; I_data_valid = 1; wr_cnt = 0;
        #1;
        chk("t1_no_wr_trig_cycle", O_fifo_wr, 0);
        tick(1);
        I_match_valid = 0; I_match_rules = 0;
        chk("t1_capture", O_state, 3);
        chk("t1_trig_out", O_trig_out, 1);
        chk("t1_trig_rule", O_trig_rule, 8'h04);
        tick(1);
        chk("t1_trig_one_cycle", O_trig_out, 0);
        chk("t1_samples1", O_samples, 1);
        tick(3);
        chk("t1_done_state", O_state, 4);
        chk("t1_done", O_done, 1);
        chk("t1_samples", O_samples, 4);
        chk("t1_not_busy", O_busy, 0);
        tick(2);
        chk("t1_wr_count", wr_cnt, 4);
        I_data_valid = 0;

        // Arm timeout of 100 cycles without sync
        I_synchronized = 0; I_timeout_cycles = 100;
        pulse_arm();
        wr_cnt = 0;
        tick(99);
        chk("t2_still_waiting", O_state, 1);
        tick(1);
        chk("t2_timeout_state", O_state, 4);
        chk("t2_timeout", O_timeout, 1);
        chk("t2_samples_cleared", O_samples, 0);
        chk("t2_rule_cleared", O_trig_rule, 0);
        chk("t2_no_writes", wr_cnt, 0);
        I_timeout_cycles = 0;
        pulse_arm();
        chk("t2_timeout_cleared", O_timeout, 0);
        tick(300);
        chk("t2_no_timeout_wait", O_state, 1);
        I_abort = 1;
        tick(1);
        I_abort = 0;
        chk("t2_abort_idle", O_state, 0);

        // Capture 8 with the FIFO full for 3 valid cycles
        I_synchronized = 1; I_capture_len = 8;
        pulse_arm();
        tick(1);
        match_trig();
        wr_cnt = 0; bad_wr = 0;
        I_data_valid = 1;
        tick(3);
        I_fifo_full = 1;
        #1;
        chk("t3_no_wr_full", O_fifo_wr, 0);
        tick(3);
        chk("t3_samples_held", O_samples, 3);
        chk("t3_overflow", O_overflow, 1);
        I_fifo_full = 0;
        tick(4);
        chk("t3_still_capture", O_state, 3);
        chk("t3_samples7", O_samples, 7);
        tick(1);
        chk("t3_done", O_state, 4);
        chk("t3_samples8", O_samples, 8);
        chk("t3_wr_count", wr_cnt, 8);
        chk("t3_wr_while_full", bad_wr, 0);
        I_data_valid = 0;

        // Soft trigger: disabled, then enabled with zero length
        I_capture_len = 0;
        pulse_arm();
        tick(1);
        I_soft_trig = 1; I_soft_trig_enable = 0;
        tick(1);
        I_soft_trig = 0;
        chk("t4_soft_disabled", O_state, 2);
        chk("t4_no_trig_out", O_trig_out, 0);
        I_soft_trig = 1; I_soft_trig_enable = 1; I_match_rules = 8'h04; I_match_valid = 0;
        tick(1);
        I_soft_trig = 0; I_match_rules = 0;
        chk("t4_len0_done", O_state, 4);
        chk("t4_trig_out", O_trig_out, 1);
        chk("t4_rule_zero", O_trig_rule, 0);
        chk("t4_samples_zero", O_samples, 0);
        tick(1);
        chk("t4_trig_pulse_end", O_trig_out, 0);

        // Sync lost after 2 of 10 writes, with a write on the drop cycle
        I_capture_len = 10;
        pulse_arm();
        tick(1);
        match_trig();
        I_data_valid = 1;
        tick(2);
        chk("t5_samples2", O_samples, 2);
        I_synchronized = 0;
        #1;
        chk("t5_wr_on_drop", O_fifo_wr, 1);
        tick(1);
        chk("t5_done", O_state, 4);
        chk("t5_sync_lost", O_sync_lost, 1);
        chk("t5_samples3", O_samples, 3);
        I_synchronized = 1; I_data_valid = 0;
        pulse_arm();
        chk("t5_rearm_state", O_state, 1);
        chk("t5_sync_lost_cleared", O_sync_lost, 0);
        chk("t5_samples_cleared", O_samples, 0);
        chk("t5_rule_cleared", O_trig_rule, 0);

        // Arm+abort during CAPTURE, then reset mid-capture
        tick(1);
        match_trig();
        I_data_valid = 1;
        tick(1);
        I_data_valid = 0;
        chk("t6_samples1", O_samples, 1);
        I_arm = 1; I_abort = 1;
        tick(1);
        I_arm = 0; I_abort = 0;
        chk("t6_abort_idle", O_state, 0);
        chk("t6_samples_hold", O_samples, 1);
        chk("t6_rule_hold", O_trig_rule, 8'h04);
        pulse_arm();
        tick(1);
        match_trig();
        I_data_valid = 1;
        tick(1);
        chk("t6_capture_again", O_state, 3);
        reset_i = 1;
        #1;
        chk("t6_no_wr_in_reset", O_fifo_wr, 0);
        tick(1);
        reset_i = 0; I_data_valid = 0;
        chk("t6_reset_state", O_state, 0);
        chk("t6_reset_samples", O_samples, 0);
        chk("t6_reset_rule", O_trig_rule, 0);
        chk("t6_reset_busy", O_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
